// File: rtl/prefix_adder32_pipe.sv
// Three-stage pipelined Kogge-Stone adder with a valid/ready handshake.
// S1 holds generate/propagate, S2 the first half of the prefix tree, S3 the result.
`timescale 1ns/1ps
module prefix_adder32_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int L = $clog2(WIDTH);
  localparam int H = (L + 1) / 2;

  logic             v1, v2, v3;
  logic             en1, en2, en3;
  logic [WIDTH-1:0] g1, pp1, p1;
  logic [WIDTH-1:0] g2, pp2, p2;
  logic             c1, c2;
  logic [WIDTH-1:0] g_in, p_in;
  logic [WIDTH-1:0] g_fold, pp_fold;

  assign en3       = !v3 || out_ready;
  assign en2       = !v2 || en3;
  assign en1       = !v1 || en2;
  assign in_ready  = en1;
  assign out_valid = v3;

  // cin is merged into bit 0 so that every prefix node ends up holding G[i:-1];
  // the group reaching below bit 0 has no propagate, hence the cleared P bit.
  assign g_in    = a & b;
  assign p_in    = a ^ b;
  assign g_fold  = {g_in[WIDTH-1:1], g_in[0] | (p_in[0] & cin)};
  assign pp_fold = {p_in[WIDTH-1:1], 1'b0};

  logic [WIDTH-1:0] lg [0:L];
  logic [WIDTH-1:0] lp [0:L-1];

  assign lg[0] = g1;
  assign lp[0] = pp1;

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    logic [WIDTH-1:0] gs, ps;
    if (k == H + 1) begin : g_src_reg
      assign gs = g2;
      assign ps = pp2;
    end else begin : g_src_comb
      assign gs = lg[k-1];
      assign ps = lp[k-1];
    end
    assign lg[k] = gs | (ps & (gs << D));
    if (k < L) begin : g_p
      assign lp[k] = ps & (ps << D);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      g1  <= '0;
      pp1 <= '0;
      p1  <= '0;
      c1  <= 1'b0;
    end else if (en1) begin
      v1  <= in_valid;
      g1  <= g_fold;
      pp1 <= pp_fold;
      p1  <= p_in;
      c1  <= cin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      g2  <= '0;
      pp2 <= '0;
      p2  <= '0;
      c2  <= 1'b0;
    end else if (en2) begin
      v2  <= v1;
      g2  <= lg[H];
      pp2 <= lp[H];
      p2  <= p1;
      c2  <= c1;
    end
  end

  // lg[L][i] is the carry into bit i+1, so the MSB pair gives signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3       <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (en3) begin
      v3       <= v2;
      sum      <= p2 ^ {lg[L][WIDTH-2:0], c2};
      carry    <= lg[L][WIDTH-1];
      overflow <= lg[L][WIDTH-1] ^ lg[L][WIDTH-2];
    end
  end

endmodule

// File: tb/tb_prefix_adder32_pipe.sv
// Bench for prefix_adder32_pipe: directed corner cases, backpressure, reset
// flush, then random traffic scored against plain integer arithmetic.
`timescale 1ns/1ps
module tb_prefix_adder32_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;

  always #5 clk = ~clk;

  prefix_adder32_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
  } txn_t;

  txn_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          outs = 0;
  logic        stall_prev = 1'b0;
  logic [33:0] held = '0;
  logic        fire_in = 1'b0;
  logic        fire_out = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {overflow, carry, sum} from integer arithmetic on the operands
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] u;
    longint      s;
    logic        ovf;
    u   = {1'b0, x} + {1'b0, y} + 33'(c);
    s   = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {ovf, u};
  endfunction

  task automatic cyc(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                     input logic ic, input logic ordy);
    txn_t        t;
    logic [33:0] e;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    out_ready = ordy;
    #1;
    if (stall_prev) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_hold", 64'({overflow, carry, sum}), 64'(held));
    end
    fire_in  = in_valid && in_ready;
    fire_out = out_valid && out_ready;
    if (fire_out) begin
      outs++;
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL out_extra observed=unexpected result expected=no result");
      end
      if (q.size() > 0) begin
        t = q.pop_front();
        e = ref_add(t.a, t.b, t.c);
        chk("sb_sum", 64'(sum), 64'(e[31:0]));
        chk("sb_carry", 64'(carry), 64'(e[32]));
        chk("sb_overflow", 64'(overflow), 64'(e[33]));
      end
    end
    stall_prev = out_valid && !out_ready;
    held       = {overflow, carry, sum};
    if (fire_in) q.push_back('{ia, ib, ic});
  endtask

  task automatic single_add(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic c, input logic [31:0] es, input logic ec, input logic eo);
    cyc(1'b1, x, y, c, 1'b1);
    chk({tag, "_accept"}, 64'(fire_in), 64'd1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk({tag, "_lat2"}, 64'(out_valid), 64'd0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk({tag, "_lat3"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(sum), 64'(es));
    chk({tag, "_carry"}, 64'(carry), 64'(ec));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
  endtask

  initial begin
    logic [31:0] bt_a [4];
    logic [31:0] bt_b [4];
    logic        bt_c [4];
    logic [31:0] bt_s [4];
    logic        bt_cy [4];
    txn_t        bp [5];
    logic [33:0] e0;
    logic [31:0] ra, rb;
    int          idx;
    int          base;

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_carry", 64'(carry), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // directed corners
    single_add("wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    single_add("ovf0", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    single_add("ovf1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0001, 1'b0, 1'b1);

    // back-to-back
    bt_a = '{32'h0000_000A, 32'h0000_0003, 32'h0000_0000, 32'h8000_0000};
    bt_b = '{32'h0000_000C, 32'h0000_000C, 32'h0000_000F, 32'h8000_0000};
    bt_c = '{1'b0, 1'b1, 1'b1, 1'b0};
    bt_s = '{32'h0000_0016, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000};
    bt_cy = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 7; k++) begin
      if (k < 4) cyc(1'b1, bt_a[k], bt_b[k], bt_c[k], 1'b1);
      else       cyc(1'b0, '0, '0, 1'b0, 1'b1);
      if (k < 4) chk("b2b_accept", 64'(fire_in), 64'd1);
      if (k >= 3) begin
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("b2b_sum", 64'(sum), 64'(bt_s[k-3]));
        chk("b2b_carry", 64'(carry), 64'(bt_cy[k-3]));
      end
    end
    chk("b2b_ovf_last", 64'(overflow), 64'd1);

    // backpressure
    for (int i = 0; i < 5; i++) bp[i] = '{$urandom, $urandom, 1'($urandom_range(1))};
    e0   = ref_add(bp[0].a, bp[0].b, bp[0].c);
    idx  = 0;
    base = outs;
    for (int k = 0; k < 40 && (outs - base) < 5; k++) begin
      if (idx < 5) cyc(1'b1, bp[idx].a, bp[idx].b, bp[idx].c, !(k >= 3 && k <= 6));
      else         cyc(1'b0, '0, '0, 1'b0, 1'b1);
      if (fire_in) idx++;
      if (k >= 3 && k <= 6) begin
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_sum", 64'(sum), 64'(e0[31:0]));
        chk("bp_hold_carry", 64'(carry), 64'(e0[32]));
      end
    end
    chk("bp_count", 64'(outs - base), 64'd5);
    chk("bp_queue_empty", 64'(q.size()), 64'd0);

    // reset with adds in flight
    cyc(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_sum", 64'(sum), 64'd0);
    chk("rst_async_carry", 64'(carry), 64'd0);
    q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      chk("rst_no_stale", 64'(out_valid), 64'd0);
    end
    single_add("post_rst", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'h0000_000D, 1'b0, 1'b0);

    // random traffic
    for (int k = 0; k < 10000; k++) begin
      case ($urandom_range(7))
        0:       ra = 32'hFFFF_FFFF;
        1:       ra = 32'h7FFF_FFFF;
        2:       ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(7) == 0) ? ~ra : $urandom;
      cyc($urandom_range(3) != 0, ra, rb, 1'($urandom_range(1)), $urandom_range(3) != 0);
    end
    for (int k = 0; k < 20 && q.size() > 0; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
